imem_arbiter: RTL
=================

# imem_arbiter

Arbitrates the single-port instruction memory between the fetch stage (reads) and the program loader (writes). It sits between both requesters and the instruction memory array. It grants one access per cycle, bounds loader bursts so fetch cannot starve, and returns fetch read data with fixed one-cycle latency.

## Interface
- INSTR_WIDTH, 32, instruction/word width
- INSTR_MEM_DEPTH, 32, memory depth in words
- MAX_LD_BURST, 4, max consecutive loader grants while fetch is pending (≥1)
- ADDR_WIDTH, $clog2(INSTR_MEM_DEPTH)+2, byte-address width (derived, not overridable)
- IDX_WIDTH, $clog2(INSTR_MEM_DEPTH), word-index width (derived)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_if_req  in  1  fetch read request
- i_if_addr  in  ADDR_WIDTH  fetch byte address
- o_if_gnt  out  1  fetch request accepted this cycle
- o_if_rvalid  out  1  fetch read data valid
- o_if_rdata  out  INSTR_WIDTH  fetch read data
- i_ld_req  in  1  loader write request
- i_ld_addr  in  ADDR_WIDTH  loader byte address
- i_ld_wdata  in  INSTR_WIDTH  loader write data
- o_ld_gnt  out  1  loader write performed this cycle
- o_mem_en  out  1  memory access enable
- o_mem_we  out  1  memory write enable
- o_mem_idx  out  IDX_WIDTH  memory word index
- o_mem_wdata  out  INSTR_WIDTH  memory write data
- i_mem_rdata  in  INSTR_WIDTH  memory read data, valid one cycle after a read enable
- o_misalign  out  1  misaligned-request pulse (only when ALIGN_CHECK is compiled in)

## Operation
- State register `owner` ∈ {IDLE, FETCH, LOAD} records last cycle's grant. A burst counter `ld_cnt` (width $clog2(MAX_LD_BURST+1)) counts consecutive loader grants.
- Grants are combinational from requests, `owner` and `ld_cnt`:
  - Loader only → loader.
  - Fetch only → fetch.
  - Both requesting → loader, unless `ld_cnt == MAX_LD_BURST`; then fetch.
  - At most one grant per cycle.
- Transitions:
  - Loader granted → LOAD; `ld_cnt` increments, saturating at MAX_LD_BURST.
  - Fetch granted → FETCH; `ld_cnt` = 0.
  - No grant → IDLE; `ld_cnt` = 0.
- Memory drive:
  - o_mem_en = any grant.
  - o_mem_we = o_ld_gnt.
  - o_mem_idx = granted address[ADDR_WIDTH-1:2].
  - o_mem_wdata = i_ld_wdata.
- Byte-address bits [1:0] are ignored (word index only) unless ALIGN_CHECK is enabled.
- A requester not granted holds its request and address; there are no queued requests.

## Timing
- Grant: same cycle as request (combinational).
- Read latency is 1:
  - o_if_rvalid is a register set to o_if_gnt.
  - o_if_rdata = i_mem_rdata when o_if_rvalid, else 0.
- Write takes effect at the grant edge. A fetch to the same index in the next cycle returns the new data.
- Back-to-back fetch grants give o_if_rvalid continuously high, one word per cycle.
- Reset values: owner=IDLE, ld_cnt=0, o_if_rvalid=0, o_if_rdata=0, o_misalign=0. Grants and memory outputs are 0 while i_reset is high.
- Reset asserted mid-access: an in-flight o_if_rvalid is dropped immediately (asynchronous), and no data is returned.

## Configuration
- IMEM_ARB_ALIGN_CHECK_EN defined:
  - A request with addr[1:0]≠0 is never granted.
  - o_misalign pulses high for one cycle (registered) per offending cycle.
  - Arbitration proceeds among the remaining requester.
- Undefined: o_misalign is tied 0, and address bits [1:0] are ignored.

## Structure
- Shared package `imem_pkg`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_FETCH, ARB_LOAD} arb_owner_t`
  - INSTR_WIDTH default
  - address/index width helper constants
- No sub-module. Arbitration and the FSM fit in one module.

## Test plan
- Fetch only: i_if_req=1, addr 0,4,8 on consecutive cycles. Expect o_if_gnt every cycle and o_mem_idx 0,1,2. o_if_rvalid goes high from cycle 2 with rdata = mem[0], mem[1], mem[2].
- Loader only: writes 0xDEADBEEF to addr 12. Expect o_ld_gnt=1, o_mem_we=1, o_mem_idx=3. A fetch of addr 12 next cycle returns 0xDEADBEEF.
- Contention with MAX_LD_BURST=4, both requesting for 10 cycles. Expect grant pattern L,L,L,L,F,L,L,L,L,F.
- Loader drops after 2 grants while fetch is pending. Expect fetch granted on cycle 3 and ld_cnt reset to 0.
- Reset pulse asserted the cycle after a fetch grant. Expect o_if_rvalid=0 immediately, owner=IDLE, and no grants during reset.
- With IMEM_ARB_ALIGN_CHECK_EN, fetch addr 6. Expect o_if_gnt=0 and o_misalign pulses 1 cycle later. A concurrent loader request to addr 8 is granted.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and default sizing for the instruction-memory arbiter.
package imem_pkg;

   // Records which requester held the memory port in the previous cycle.
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_FETCH = 2'd1,
      ARB_LOAD  = 2'd2
   } arb_owner_t;

   localparam int IMEM_INSTR_WIDTH  = 32;
   localparam int IMEM_DEPTH        = 32;
   localparam int IMEM_MAX_LD_BURST = 4;

   // Word-index width for a memory of the given depth (at least one bit).
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Byte-address width: word index plus the two byte-offset bits.
   function automatic int addr_width(input int depth);
      return idx_width(depth) + 2;
   endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the fetch stage, the program loader, the memory array
// and the arbiter. The slave modport is the arbiter's view; master is the
// surrounding environment (requesters and memory).
//
// Handshake: a requester raises i_*_req with a stable address (and data)
// and holds them until the matching o_*_gnt is seen high in the same cycle;
// a grant means the access happened at the following rising edge. Fetch
// data arrives with o_if_rvalid exactly one cycle after o_if_gnt.
interface imem_arbiter_if
   import imem_pkg::*;
#(
   parameter int INSTR_WIDTH     = IMEM_INSTR_WIDTH,
   parameter int INSTR_MEM_DEPTH = IMEM_DEPTH
) ();

   localparam int ADDR_WIDTH = addr_width(INSTR_MEM_DEPTH);
   localparam int IDX_WIDTH  = idx_width(INSTR_MEM_DEPTH);

   // fetch side
   logic                   i_if_req;
   logic [ADDR_WIDTH-1:0]  i_if_addr;
   logic                   o_if_gnt;
   logic                   o_if_rvalid;
   logic [INSTR_WIDTH-1:0] o_if_rdata;
   // loader side
   logic                   i_ld_req;
   logic [ADDR_WIDTH-1:0]  i_ld_addr;
   logic [INSTR_WIDTH-1:0] i_ld_wdata;
   logic                   o_ld_gnt;
   // memory side
   logic                   o_mem_en;
   logic                   o_mem_we;
   logic [IDX_WIDTH-1:0]   o_mem_idx;
   logic [INSTR_WIDTH-1:0] o_mem_wdata;
   logic [INSTR_WIDTH-1:0] i_mem_rdata;
   // alignment error pulse
   logic                   o_misalign;

   modport slave (
      input  i_if_req, i_if_addr, i_ld_req, i_ld_addr, i_ld_wdata, i_mem_rdata,
      output o_if_gnt, o_if_rvalid, o_if_rdata, o_ld_gnt,
             o_mem_en, o_mem_we, o_mem_idx, o_mem_wdata, o_misalign
   );

   modport master (
      output i_if_req, i_if_addr, i_ld_req, i_ld_addr, i_ld_wdata, i_mem_rdata,
      input  o_if_gnt, o_if_rvalid, o_if_rdata, o_ld_gnt,
             o_mem_en, o_mem_we, o_mem_idx, o_mem_wdata, o_misalign
   );

endinterface

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: fetch reads vs. loader writes.
// The loader wins contention until it has held the port for MAX_LD_BURST
// consecutive cycles, then fetch gets one slot. Fetch data returns one
// cycle after grant.
// Optional build macro IMEM_ARB_ALIGN_CHECK_EN: requests with a nonzero
// byte offset are refused and flagged on o_misalign one cycle later.
module imem_arbiter
   import imem_pkg::*;
#(
   parameter int  INSTR_WIDTH     = IMEM_INSTR_WIDTH,
   parameter int  INSTR_MEM_DEPTH = IMEM_DEPTH,
   parameter int  MAX_LD_BURST    = IMEM_MAX_LD_BURST,
   localparam int ADDR_WIDTH      = addr_width(INSTR_MEM_DEPTH),
   localparam int IDX_WIDTH       = idx_width(INSTR_MEM_DEPTH),
   localparam int CNT_WIDTH       = $clog2(MAX_LD_BURST + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   imem_arbiter_if.slave        bus,
   output arb_owner_t           o_dbg_owner,
   output logic [CNT_WIDTH-1:0] o_dbg_ld_cnt
);

   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_LD_BURST);

   arb_owner_t           owner_q, owner_d;
   logic [CNT_WIDTH-1:0] ld_cnt_q, ld_cnt_d;
   logic                 if_rvalid_q, if_rvalid_d;
   logic                 misalign_q, misalign_d;

   logic fetch_ok;
   logic load_ok;
   logic if_gnt;
   logic ld_gnt;

`ifdef IMEM_ARB_ALIGN_CHECK_EN
   assign fetch_ok   = bus.i_if_req && (bus.i_if_addr[1:0] == 2'b00);
   assign load_ok    = bus.i_ld_req && (bus.i_ld_addr[1:0] == 2'b00);
   assign misalign_d = (bus.i_if_req && (bus.i_if_addr[1:0] != 2'b00)) ||
                       (bus.i_ld_req && (bus.i_ld_addr[1:0] != 2'b00));
`else
   // Byte offsets are simply dropped: every request maps to its word.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.i_if_addr[1:0], bus.i_ld_addr[1:0]};
   assign fetch_ok   = bus.i_if_req;
   assign load_ok    = bus.i_ld_req;
   assign misalign_d = 1'b0;
`endif

   // State register: last owner, loader burst length, read-valid, misalign.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         owner_q     <= ARB_IDLE;
         ld_cnt_q    <= '0;
         if_rvalid_q <= 1'b0;
         misalign_q  <= 1'b0;
      end else begin
         owner_q     <= owner_d;
         ld_cnt_q    <= ld_cnt_d;
         if_rvalid_q <= if_rvalid_d;
         misalign_q  <= misalign_d;
      end
   end

   // Next state: follow this cycle's grant; loader bursts saturate.
   always_comb begin
      owner_d     = ARB_IDLE;
      ld_cnt_d    = '0;
      if_rvalid_d = if_gnt;
      if (ld_gnt) begin
         owner_d  = ARB_LOAD;
         ld_cnt_d = (ld_cnt_q == MAX_CNT) ? ld_cnt_q : ld_cnt_q + CNT_WIDTH'(1);
      end else if (if_gnt) begin
         owner_d  = ARB_FETCH;
      end
   end

   // Outputs: grant selection and memory port drive, all quiet in reset.
   always_comb begin
      if_gnt = 1'b0;
      ld_gnt = 1'b0;
      if (!i_reset) begin
         if (load_ok && (!fetch_ok || (ld_cnt_q != MAX_CNT))) begin
            ld_gnt = 1'b1;
         end else if (fetch_ok) begin
            if_gnt = 1'b1;
         end
      end
      bus.o_if_gnt    = if_gnt;
      bus.o_ld_gnt    = ld_gnt;
      bus.o_mem_en    = if_gnt | ld_gnt;
      bus.o_mem_we    = ld_gnt;
      bus.o_mem_idx   = '0;
      if (ld_gnt) begin
         bus.o_mem_idx = bus.i_ld_addr[ADDR_WIDTH-1:2];
      end else if (if_gnt) begin
         bus.o_mem_idx = bus.i_if_addr[ADDR_WIDTH-1:2];
      end
      bus.o_mem_wdata = i_reset ? '0 : bus.i_ld_wdata;
   end

   // Read data is only passed through while a fetch response is due.
   assign bus.o_if_rvalid = if_rvalid_q;
   assign bus.o_if_rdata  = if_rvalid_q ? bus.i_mem_rdata : '0;
   assign bus.o_misalign  = misalign_q;

   assign o_dbg_owner  = owner_q;
   assign o_dbg_ld_cnt = ld_cnt_q;

endmodule
